module_btb_param: RTL and testbench
===================================

MODULE_BTB_PARAM -- requirements
Module: module_btb_param

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, address/target width.
REQ-002 The block SHALL have parameter DEPTH, default 16, entry count; power of two, range 2..256.
REQ-003 The block SHALL have parameter CNT_W, default 2, saturating-counter width; range 1..4.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 pc_f_i  in  XLEN  fetch-stage PC to look up.
REQ-007 hit_o  out  1  valid entry with matching tag at the pc_f_i index.
REQ-008 predict_o  out  1  predict taken: hit_o AND counter MSB.
REQ-009 target_o  out  XLEN  stored target of the indexed entry.
REQ-010 upd_en_i  in  1  execute-stage branch/jump resolved this cycle.
REQ-011 upd_pc_i  in  XLEN  PC of the resolved branch.
REQ-012 upd_target_i  in  XLEN  resolved target address.
REQ-013 upd_taken_i  in  1  resolved direction, 1 = taken.
REQ-014 inval_req_i  in  1  request to invalidate all entries.
REQ-015 busy_o  out  1  invalidation sweep in progress.

Function
REQ-016 IDX_W SHALL equal log2(DEPTH); index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-017 Each entry SHALL hold valid (1 bit), tag, target (XLEN) and counter (CNT_W, unsigned).
REQ-018 Lookup SHALL be combinational from pc_f_i and current entry state; zero-cycle latency.
REQ-019 An update SHALL become visible to lookup on the cycle after its clock edge; no same-cycle write-to-read bypass.
REQ-020 Update on hit (valid, tag match at upd_pc_i index): counter +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0.
REQ-021 Update on hit with upd_taken_i=1 SHALL also overwrite target with upd_target_i.
REQ-022 Update on miss with upd_taken_i=1 SHALL allocate: valid=1, tag and target written, counter = 2^(CNT_W-1) (weakly taken); the existing entry SHALL be replaced.
REQ-023 Update on miss with upd_taken_i=0 SHALL leave the table unchanged.
REQ-024 FSM states: IDLE, CLEAR; sweep index register of IDX_W bits.
REQ-025 IDLE with inval_req_i=1 SHALL go to CLEAR with sweep index 0; any update that same cycle SHALL still be written.
REQ-026 CLEAR SHALL clear valid and zero the counter of one entry per cycle at the sweep index, then increment the index.
REQ-027 CLEAR SHALL return to IDLE after clearing index DEPTH-1; the sweep SHALL take exactly DEPTH cycles.
REQ-028 In CLEAR, busy_o=1, hit_o=0 and predict_o=0; upd_en_i and inval_req_i SHALL be ignored.
REQ-029 busy_o SHALL be registered, asserting the cycle after the request edge and deasserting the cycle after the final clear.

Reset
REQ-030 rst_i low SHALL immediately force all valid bits, counters, tags, targets, sweep index to 0 and the FSM to IDLE.
REQ-031 After reset, hit_o=0, predict_o=0, target_o=0, busy_o=0.
REQ-032 Reset asserted during CLEAR SHALL abort the sweep; after release the FSM SHALL be IDLE.

Verification
REQ-033 Reset, pc_f_i=0x40 -> hit_o=0, predict_o=0, target_o=0, busy_o=0.
REQ-034 Update pc=0x40, target=0x100, taken=1 -> next cycle, with pc_f_i=0x40: hit_o=1, predict_o=1, target_o=0x100, counter=2.
REQ-035 Then 2 not-taken updates to 0x40 -> counter 1 then 0, predict_o=0, hit_o=1; a 3rd not-taken update keeps counter 0; 3 taken updates -> counter saturates at 3.
REQ-036 DEPTH=16: entry at 0x40, then taken update at 0x80 (same index, different tag) -> lookup 0x40 hit_o=0; lookup 0x80 hit_o=1, counter=2.
REQ-037 Fill 4 entries, pulse inval_req_i with a simultaneous update -> busy_o high for exactly 16 cycles, updates during the sweep dropped, all lookups miss afterwards.
REQ-038 Assert rst_i low at sweep index 5 -> busy_o=0 immediately; after release the FSM is IDLE and all entries are invalid.

Source files
------------

// File: rtl/module_btb_param.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and a one-entry-per-cycle invalidation sweep.
module module_btb_param #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_f_i,
    output logic            hit_o,
    output logic            predict_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_taken_i,
    input  logic            inval_req_i,
    output logic            busy_o
);
    // state | meaning
    // IDLE  | lookups and updates active
    // CLEAR | sweeping entries invalid, one per cycle; updates ignored
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic              busy_q, busy_d;
    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];
    logic [XLEN-1:0]   tgt_q   [DEPTH];
    logic [XLEN-1:0]   tgt_d   [DEPTH];
    logic [CNT_W-1:0]  cnt_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_d   [DEPTH];

    logic [IDX_W-1:0]  f_idx, u_idx;
    logic [TAG_W-1:0]  f_tag, u_tag;
    logic              u_hit;
    logic              unused_pc_lsbs;

    assign f_idx = pc_f_i[IDX_W+1:2];
    assign f_tag = pc_f_i[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign unused_pc_lsbs = ^{pc_f_i[1:0], upd_pc_i[1:0]};

    // Lookup reads registered state only, so updates appear one cycle later.
    assign hit_o     = (state_q == IDLE) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign predict_o = hit_o && cnt_q[f_idx][CNT_W-1];
    assign target_o  = tgt_q[f_idx];
    assign busy_o    = busy_q;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (upd_en_i) begin
                    if (u_hit) begin
                        if (upd_taken_i) begin
                            tgt_d[u_idx] = upd_target_i;
                            if (cnt_q[u_idx] != CNT_MAX) cnt_d[u_idx] = cnt_q[u_idx] + CNT_W'(1);
                        end else if (cnt_q[u_idx] != '0) begin
                            cnt_d[u_idx] = cnt_q[u_idx] - CNT_W'(1);
                        end
                    end else if (upd_taken_i) begin
                        valid_d[u_idx] = 1'b1;
                        tag_d[u_idx]   = u_tag;
                        tgt_d[u_idx]   = upd_target_i;
                        cnt_d[u_idx]   = CNT_INIT;
                    end
                end
                if (inval_req_i) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            CLEAR: begin
                valid_d[sweep_q] = 1'b0;
                cnt_d[sweep_q]   = '0;
                sweep_d          = sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            sweep_q <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_module_btb_param.sv
// Directed bench for module_btb_param at default parameters (XLEN=32, DEPTH=16, CNT_W=2).
module tb_module_btb_param;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_f_i = 32'h40;
    logic        hit_o, predict_o, busy_o;
    logic [31:0] target_o;
    logic        upd_en_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic [31:0] upd_target_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        inval_req_i = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    module_btb_param dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_f_i(pc_f_i), .hit_o(hit_o),
        .predict_o(predict_o), .target_o(target_o), .upd_en_i(upd_en_i),
        .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i),
        .inval_req_i(inval_req_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Apply one update across a clock edge; outputs are sampled 1 ns after the edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        upd_en_i = 1'b1; upd_pc_i = pc; upd_target_i = tgt; upd_taken_i = taken;
        @(posedge clk_i); #1;
        upd_en_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic pred, input logic [31:0] tgt);
        pc_f_i = pc; #1;
        check({tag, ".hit"}, 32'(hit_o), 32'(hit));
        check({tag, ".pred"}, 32'(predict_o), 32'(pred));
        if (hit) check({tag, ".tgt"}, target_o, tgt);
    endtask

    initial begin
        int cyc;
        logic [31:0] miss_pcs [7] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h80};

        #1;
        check("rst.hit", 32'(hit_o), 0);
        check("rst.pred", 32'(predict_o), 0);
        check("rst.tgt", target_o, 0);
        check("rst.busy", 32'(busy_o), 0);
        #21 rst_i = 1'b1;
        @(posedge clk_i); #1;

        // No same-cycle bypass, then visible next cycle as weakly taken.
        upd_en_i = 1'b1; upd_pc_i = 32'h40; upd_target_i = 32'h100; upd_taken_i = 1'b1;
        pc_f_i = 32'h40; #1;
        check("bypass.hit", 32'(hit_o), 0);
        @(posedge clk_i); #1;
        upd_en_i = 1'b0;
        look("alloc", 32'h40, 1, 1, 32'h100);

        upd(32'h40, 32'h999, 0); look("nt1", 32'h40, 1, 0, 32'h100);
        upd(32'h40, 32'h999, 0); look("nt2", 32'h40, 1, 0, 32'h100);
        upd(32'h40, 32'h999, 0); look("nt3", 32'h40, 1, 0, 32'h100);
        upd(32'h40, 32'h100, 1); look("t1", 32'h40, 1, 0, 32'h100);
        upd(32'h40, 32'h104, 1); look("t2", 32'h40, 1, 1, 32'h104);
        upd(32'h40, 32'h104, 1); look("t3", 32'h40, 1, 1, 32'h104);
        upd(32'h40, 32'h104, 1); look("t4sat", 32'h40, 1, 1, 32'h104);
        upd(32'h40, 32'h104, 0); look("dn3", 32'h40, 1, 1, 32'h104);
        upd(32'h40, 32'h104, 0); look("dn2", 32'h40, 1, 0, 32'h104);

        // Not-taken miss leaves the table alone.
        upd(32'hC0, 32'h500, 0);
        look("ntmiss.old", 32'h40, 1, 0, 32'h104);
        look("ntmiss.new", 32'hC0, 0, 0, 0);

        // Same index, different tag replaces the entry at weakly-taken.
        upd(32'h80, 32'h200, 1);
        look("repl.old", 32'h40, 0, 0, 0);
        look("repl.new", 32'h80, 1, 1, 32'h200);
        look("repl.lsb", 32'h83, 1, 1, 32'h200);
        upd(32'h80, 32'h200, 0);
        look("repl.cnt1", 32'h80, 1, 0, 32'h200);

        upd(32'h44, 32'h244, 1);
        upd(32'h48, 32'h248, 1);
        upd(32'h4C, 32'h24C, 1);
        look("fill", 32'h4C, 1, 1, 32'h24C);

        // Invalidate with a simultaneous update; hold junk requests during the sweep.
        inval_req_i = 1'b1;
        upd_en_i = 1'b1; upd_pc_i = 32'h50; upd_target_i = 32'h300; upd_taken_i = 1'b1;
        pc_f_i = 32'h50;
        @(posedge clk_i); #1;
        upd_pc_i = 32'h54;
        check("inv.busy", 32'(busy_o), 1);
        check("inv.hitgate", 32'(hit_o), 0);
        cyc = 0;
        while (busy_o && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == 10) begin
                inval_req_i = 1'b0;
                upd_en_i = 1'b0;
            end
        end
        check("inv.cycles", 32'(cyc), 16);
        foreach (miss_pcs[i]) begin
            pc_f_i = miss_pcs[i]; #1;
            check($sformatf("inv.miss%0d", i), 32'(hit_o), 0);
        end

        // Reset in the middle of a sweep.
        upd(32'h40, 32'h100, 1);
        look("pre2", 32'h40, 1, 1, 32'h100);
        inval_req_i = 1'b1;
        @(posedge clk_i); #1;
        inval_req_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1 check("rstmid.busy", 32'(busy_o), 0);
        #4 rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rstmid.busy2", 32'(busy_o), 0);
        look("rstmid.miss", 32'h40, 0, 0, 0);
        upd(32'h48, 32'h448, 1);
        look("rstmid.idle", 32'h48, 1, 1, 32'h448);
        check("rstmid.busy3", 32'(busy_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
